// File: rtl/tiny16_out_uart.sv
// rtl/tiny16_out_uart.sv - UART TX of the tiny16 OUT register as four hex digits plus CR LF on each change
module tiny16_out_uart #(
    parameter int CLKS_PER_BIT = 139
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] OUT_IN,
    output logic        TX,
    output logic        BUSY,
    output logic        OVERRUN
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [15:0] last_q, last_d;
    logic [15:0] pend_q, pend_d;
    logic [15:0] msg_q, msg_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  byte_q, byte_d;
    logic [2:0]  bit_q, bit_d;
    logic        pend_v_q, pend_v_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        overrun_q, overrun_d;
    logic [7:0]  cur_byte;
    logic        change, consume, cnt_wrap;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] msg_byte(input logic [15:0] m, input logic [2:0] idx);
        case (idx)
            3'd0:    return hex_ascii(m[15:12]);
            3'd1:    return hex_ascii(m[11:8]);
            3'd2:    return hex_ascii(m[7:4]);
            3'd3:    return hex_ascii(m[3:0]);
            3'd4:    return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        msg_d     = msg_q;
        cnt_d     = cnt_q;
        byte_d    = byte_q;
        bit_d     = bit_q;
        busy_d    = busy_q;
        overrun_d = overrun_q;
        change    = (OUT_IN != last_q);
        consume   = (state_q == IDLE) && pend_v_q;
        cnt_wrap  = (cnt_q == CNT_LAST);

        case (state_q)
            IDLE: begin
                if (pend_v_q) begin
                    msg_d    = pend_q;
                    pend_v_d = 1'b0;
                    byte_d   = 3'd0;
                    cnt_d    = 16'd0;
                    busy_d   = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                if (cnt_wrap) begin
                    cnt_d   = 16'd0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (cnt_wrap) begin
                    cnt_d = 16'd0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                if (cnt_wrap) begin
                    cnt_d = 16'd0;
                    if (byte_q < 3'd5) begin
                        byte_d  = byte_q + 3'd1;
                        state_d = START;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        endcase

        // A change wins over consumption; overrun only if the old entry was not taken this cycle
        if (change) begin
            last_d   = OUT_IN;
            pend_d   = OUT_IN;
            pend_v_d = 1'b1;
            if (pend_v_q && !consume) begin
                overrun_d = 1'b1;
            end
        end

        // TX is registered from the next-state view so each bit starts exactly on the counter wrap
        cur_byte = msg_byte(msg_d, byte_d);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            last_q    <= 16'h0000;
            pend_q    <= 16'h0000;
            pend_v_q  <= 1'b0;
            msg_q     <= 16'h0000;
            cnt_q     <= 16'd0;
            byte_q    <= 3'd0;
            bit_q     <= 3'd0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            pend_q    <= pend_d;
            pend_v_q  <= pend_v_d;
            msg_q     <= msg_d;
            cnt_q     <= cnt_d;
            byte_q    <= byte_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign TX      = tx_q;
    assign BUSY    = busy_q;
    assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_tiny16_out_uart.sv
// tb/tb_tiny16_out_uart.sv - scoreboard bench for tiny16_out_uart with a bit-sampling UART receiver
module tb_tiny16_out_uart;

    localparam int CPB = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] out_val;
    logic        tx;
    logic        busy;
    logic        overrun;

    int          tests_run;
    int          tests_failed;
    int          cyc;
    logic [7:0]  exp_q[$];

    tiny16_out_uart #(.CLKS_PER_BIT(CPB)) dut (
        .CLK     (clk),
        .RST     (rst_n),
        .OUT_IN  (out_val),
        .TX      (tx),
        .BUSY    (busy),
        .OVERRUN (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] hexc(input logic [3:0] n);
        logic [7:0] tbl[16];
        tbl = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
        return tbl[n];
    endfunction

    task automatic push_msg(input logic [15:0] v);
        exp_q.push_back(hexc(v[15:12]));
        exp_q.push_back(hexc(v[11:8]));
        exp_q.push_back(hexc(v[7:4]));
        exp_q.push_back(hexc(v[3:0]));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic do_reset();
        out_val = 16'h0000;
        rst_n   = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Receives one frame; sc is the cycle on which the start bit was first seen low
    task automatic recv_byte(output int sc);
        int         n;
        logic [7:0] b;
        logic [7:0] e;
        logic       st;
        logic       stp;
        n = 0;
        b = 8'h00;
        while (tx !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n >= 2000) begin
            tests_failed++;
            $display("FAIL rx_start_timeout: no start bit after %0d cycles, required within 2000", n);
            sc = -1;
            return;
        end
        sc = cyc;
        repeat (CPB / 2) @(negedge clk);
        st = tx;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        stp = tx;
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL rx_unexpected: got byte %h, required no byte", b);
        end else begin
            e = exp_q.pop_front();
            if (b !== e || st !== 1'b0 || stp !== 1'b1) begin
                tests_failed++;
                $display("FAIL rx_byte: got %h start=%b stop=%b, required %h start=0 stop=1", b, st, stp, e);
            end
        end
    endtask

    task automatic wait_busy_low(output int fall_cyc);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        fall_cyc = cyc;
    endtask

    task automatic test_reset();
        int bad;
        do_reset();
        tests_run++;
        if (tx !== 1'b1 || busy !== 1'b0 || overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: tx=%b busy=%b overrun=%b, required 1 0 0", tx, busy, overrun);
        end
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL zero_hold: %0d active cycles, required 0", bad);
        end
    endtask

    task automatic test_single();
        int c0, s0, s1, sx, fall;
        do_reset();
        c0 = cyc;
        out_val = 16'h12AF;
        push_msg(16'h12AF);
        recv_byte(s0);
        recv_byte(s1);
        for (int i = 2; i < 6; i++) recv_byte(sx);
        wait_busy_low(fall);
        tests_run++;
        if (s0 - c0 !== 2) begin
            tests_failed++;
            $display("FAIL start_latency: %0d cycles, required 2", s0 - c0);
        end
        tests_run++;
        if (s1 - s0 !== 10 * CPB) begin
            tests_failed++;
            $display("FAIL byte_period: %0d cycles, required %0d", s1 - s0, 10 * CPB);
        end
        tests_run++;
        if (fall - s0 !== 60 * CPB) begin
            tests_failed++;
            $display("FAIL busy_length: %0d cycles, required %0d", fall - s0, 60 * CPB);
        end
    endtask

    task automatic test_back_to_back();
        int c0, fall;
        int s[12];
        do_reset();
        c0 = cyc;
        out_val = 16'h0001;
        push_msg(16'h0001);
        fork
            begin
                repeat (50) @(negedge clk);
                out_val = 16'hBEEF;
                push_msg(16'hBEEF);
            end
            begin
                for (int i = 0; i < 12; i++) recv_byte(s[i]);
            end
        join
        wait_busy_low(fall);
        tests_run++;
        if (s[0] - c0 !== 2) begin
            tests_failed++;
            $display("FAIL b2b_latency: %0d cycles, required 2", s[0] - c0);
        end
        tests_run++;
        if (s[6] - s[0] !== 60 * CPB + 1) begin
            tests_failed++;
            $display("FAIL b2b_gap: %0d cycles, required %0d", s[6] - s[0], 60 * CPB + 1);
        end
        tests_run++;
        if (overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_overrun: %b, required 0", overrun);
        end
    endtask

    task automatic test_overrun();
        int sx, bad;
        do_reset();
        out_val = 16'h0A0A;
        push_msg(16'h0A0A);
        fork
            begin
                repeat (30) @(negedge clk);
                out_val = 16'h1111;
                repeat (2) @(negedge clk);
                tests_run++;
                if (overrun !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL ovr_first_pending: %b, required 0", overrun);
                end
                repeat (28) @(negedge clk);
                out_val = 16'h2222;
                repeat (30) @(negedge clk);
                out_val = 16'h3333;
                push_msg(16'h3333);
            end
            begin
                for (int i = 0; i < 12; i++) recv_byte(sx);
            end
        join
        tests_run++;
        if (overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovr_sticky: %b, required 1", overrun);
        end
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL ovr_extra_msg: %0d low cycles, required 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        int sx, n, fall;
        do_reset();
        out_val = 16'h5A3C;
        push_msg(16'h5A3C);
        fork
            begin
                repeat (20) @(negedge clk);
                out_val = 16'h7777;
                repeat (30) @(negedge clk);
                out_val = 16'h9999;
            end
            begin
                recv_byte(sx);
                recv_byte(sx);
            end
        join
        n = 0;
        while (tx !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (13) @(negedge clk);
        tests_run++;
        if (tx !== 1'b0 || overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_precondition: tx=%b overrun=%b, required 0 1", tx, overrun);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (tx !== 1'b1 || busy !== 1'b0 || overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: tx=%b busy=%b overrun=%b, required 1 0 0", tx, busy, overrun);
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push_msg(16'h9999);
        for (int i = 0; i < 6; i++) recv_byte(sx);
        wait_busy_low(fall);
    endtask

    task automatic test_sweep();
        int sx, fall;
        do_reset();
        out_val = 16'hFFFF;
        push_msg(16'hFFFF);
        for (int i = 0; i < 6; i++) recv_byte(sx);
        out_val = 16'h0A09;
        push_msg(16'h0A09);
        for (int i = 0; i < 6; i++) recv_byte(sx);
        wait_busy_low(fall);
        tests_run++;
        if (exp_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL sweep_leftover: %0d bytes unreceived, required 0", exp_q.size());
        end
    endtask

    initial begin
        clk          = 1'b0;
        rst_n        = 1'b0;
        out_val      = 16'h0000;
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
